dense_vec_serializer: RTL and testbench
=======================================

# dense_vec_serializer

Converts the wide, single-pulse result vector of a dense layer (VEC_SIZE elements valid for one cycle) into a stream of CHUNK-element beats that feeds the next dense layer's `vld_in`/`data_in` port. It sits between consecutive dense layers in the classifier datapath. A ping-pong buffer lets a new vector land while the previous one is still draining. It optionally applies ReLU at load time and supports downstream back-pressure.

## Interface
- `VEC_SIZE`, 128: elements per incoming vector; must be a multiple of CHUNK.
- `CHUNK`, 4: elements per output beat; equals the consumer's INPUT_SIZE.
- `BW`, 16: element width, two's complement.
- `RELU`, 1: 1 = clamp negative elements to 0 on load; 0 = pass through.
- Derived: NUM_BEATS = VEC_SIZE/CHUNK; beat counter width = max(1, $clog2(NUM_BEATS)).

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `vld_in`  in  1  single-cycle pulse; `data_in` holds a complete vector.
- `data_in`  in  [VEC_SIZE][BW]  element i = `data_in[i]`.
- `rdy_out`  in  1  downstream accepts a beat this cycle.
- `vld_out`  out  1  a beat is presented on `data_out`.
- `data_out`  out  [CHUNK][BW]  `data_out[j]` = vec[beat*CHUNK + j].
- `last_out`  out  1  the presented beat is beat NUM_BEATS-1.
- `busy`  out  1  at least one bank is full.
- `overflow`  out  1  sticky; a vector was dropped.

## Operation
- Two banks, A and B, each holding VEC_SIZE×BW bits plus a `full` flag. The banks themselves are not reset.
- Pointers: `wr_sel` selects the next bank to load and `rd_sel` selects the bank being drained. Both reset to A.
- Load: when `vld_in`=1 and bank `wr_sel` is free, store `data_in` into that bank, applying ReLU when RELU=1 (MSB=1 → 0). Set `full` and toggle `wr_sel`.
- A bank counts as free if `full`=0, or if it is bank `rd_sel` and its last beat transfers this cycle. That last-beat case is the simultaneous load/free event and must be accepted.
- Drop: when `vld_in`=1 and no bank is free, discard the vector, set `overflow`=1 (held until reset), and leave the banks untouched.
- Drain:
  - `vld_out` = `full[rd_sel]`.
  - A beat transfers when `vld_out && rdy_out`; on transfer the beat counter increments.
  - On transfer of beat NUM_BEATS-1: clear `full[rd_sel]`, reset the beat counter to 0, and toggle `rd_sel`.
- Back-pressure: with `rdy_out`=0, `data_out`, `last_out` and the beat counter hold. Gaps are legal because the consumer advances only on its `vld_in`.
- `data_out` is forced to 0 whenever `vld_out`=0. `last_out` = `vld_out && beat == NUM_BEATS-1`.
- `busy` = `full[A] | full[B]`.
- Degenerate case NUM_BEATS=1: every transfer is a last beat.

## Timing
- Reset values: `vld_out`=0, `data_out`=0, `last_out`=0, `busy`=0, `overflow`=0. All pointers, flags and counters are 0 (bank A).
- Asserting `rst_n` low mid-drain empties both banks immediately. The partially sent vector is abandoned.
- Load latency: `vld_in` at edge t gives `vld_out`=1 in the cycle after edge t, with beat 0.
- Throughput: one beat per cycle with `rdy_out` held high. A vector drains in NUM_BEATS cycles.
- Back-to-back drain: after the last beat of bank A transfers, beat 0 of bank B is presented in the next cycle if B is full. There is no bubble.
- Outputs are functions of registered state only. There is no combinational path from `vld_in`, `data_in` or `rdy_out` to any output.

## Structure
- Package `dense_pkg`:
  - function `relu(logic signed [BW-1:0])`;
  - typedef `bank_sel_t` (A/B enum);
  - helper for the beat-counter width.
- Sub-module `vec_bank`:
  - one VEC_SIZE×BW store with load enable, optional ReLU, and a CHUNK-wide read mux indexed by beat;
  - instantiated twice.
- Top level holds `wr_sel`, `rd_sel`, the `full` flags, the beat counter, `overflow`, and the output mux/zero-mask.

## Test plan
All scenarios use VEC_SIZE=8, CHUNK=4, BW=16, RELU=1.
- **Basic load/drain:** reset; pulse `vld_in` with elements 1..8 and `rdy_out`=1. Expect {1,2,3,4} then {5,6,7,8} on consecutive cycles; `last_out` high on the second beat only; `busy` falls afterward.
- **ReLU:** pulse elements {-3,2,-1,0,5,-32768,7,1}. Expect beats {0,2,0,0} and {5,0,7,1}. Repeat with RELU=0 and expect the values unchanged.
- **Back-pressure:** hold `rdy_out`=0 for 5 cycles after load. `vld_out`=1 with beat 0 stable throughout; release, then beat 1 follows; total transfers = 2.
- **Ping-pong and simultaneous event:** load vector V1; load V2 one cycle later; load V3 on the cycle V1's last beat transfers. Expect V1, V2, V3 drained in order, gap-free, with `overflow`=0.
- **Overflow:** hold `rdy_out`=0, load V1, V2, then V3. Expect `overflow`=1 persisting; on release only V1 and V2 are emitted.
- **Async reset mid-drain:** drop `rst_n` between beats, asynchronous to `clk`. All outputs go to 0 immediately; after release, a new vector drains correctly starting from bank A.

Source files
------------

// File: rtl/dense_pkg.sv
// Shared types and helpers for the dense-layer vector serializer.
package dense_pkg;

    localparam int MAX_BW = 64;

    typedef enum logic {
        BANK_A = 1'b0,
        BANK_B = 1'b1
    } bank_sel_t;

    function automatic int beat_cnt_w(input int num_beats);
        return (num_beats <= 1) ? 1 : $clog2(num_beats);
    endfunction

    // Works at MAX_BW so any element width up to 64 can be sign-extended into it.
    function automatic logic signed [MAX_BW-1:0] relu(input logic signed [MAX_BW-1:0] x);
        return x[MAX_BW-1] ? '0 : x;
    endfunction

endpackage

// File: rtl/vec_bank.sv
// One vector store: loads a full vector (optionally ReLU-clamped), reads CHUNK elements per beat.
// Zero-latency read mux; load takes effect on the next clk edge; no flow control of its own.
module vec_bank
    import dense_pkg::*;
#(
    parameter int VEC_SIZE = 128,
    parameter int CHUNK    = 4,
    parameter int BW       = 16,
    parameter int RELU     = 1,
    parameter int CW       = 5
) (
    input  logic                         clk,
    input  logic                         load,
    input  logic [VEC_SIZE-1:0][BW-1:0]  data_in,
    input  logic [CW-1:0]                beat,
    output logic [CHUNK-1:0][BW-1:0]     data_out
);

    localparam int IW = beat_cnt_w(VEC_SIZE);

    logic [VEC_SIZE-1:0][BW-1:0] mem;

    function automatic logic [BW-1:0] load_val(input logic [BW-1:0] d);
        logic signed [MAX_BW-1:0] ext;
        ext = MAX_BW'(signed'(d));
        return (RELU != 0) ? BW'(relu(ext)) : d;
    endfunction

    // Payload storage is deliberately unreset; the owner's full flag qualifies it.
    always_ff @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < VEC_SIZE; i++) begin
                mem[i] <= load_val(data_in[i]);
            end
        end
    end

    always_comb begin
        data_out = '0;
        for (int j = 0; j < CHUNK; j++) begin
            data_out[j] = mem[IW'(int'(beat) * CHUNK + j)];
        end
    end

endmodule

// File: rtl/dense_vec_serializer.sv
// Ping-pong serializer: wide single-pulse vector in, CHUNK-element beats out, first beat one cycle after load.
// rdy_out low holds the current beat; a vector arriving with both banks occupied is dropped and flagged.
module dense_vec_serializer
    import dense_pkg::*;
#(
    parameter int VEC_SIZE = 128,
    parameter int CHUNK    = 4,
    parameter int BW       = 16,
    parameter int RELU     = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         vld_in,
    input  logic [VEC_SIZE-1:0][BW-1:0]  data_in,
    input  logic                         rdy_out,
    output logic                         vld_out,
    output logic [CHUNK-1:0][BW-1:0]     data_out,
    output logic                         last_out,
    output logic                         busy,
    output logic                         overflow
);

    localparam int NUM_BEATS = VEC_SIZE / CHUNK;
    localparam int CW        = beat_cnt_w(NUM_BEATS);
    localparam logic [CW-1:0] LAST_BEAT = CW'(NUM_BEATS - 1);

    logic [1:0]          full;
    bank_sel_t           wr_sel;
    bank_sel_t           rd_sel;
    logic [CW-1:0]       beat;
    logic                xfer;
    logic                xfer_last;
    logic                wr_free;
    logic                accept;
    logic [CHUNK-1:0][BW-1:0] rd_a;
    logic [CHUNK-1:0][BW-1:0] rd_b;

    assign vld_out   = full[rd_sel];
    assign xfer      = vld_out && rdy_out;
    assign xfer_last = xfer && (beat == LAST_BEAT);
    // The bank being drained counts as free on its final beat, so a load can land in the same cycle.
    assign wr_free   = !full[wr_sel] || ((wr_sel == rd_sel) && xfer_last);
    assign accept    = vld_in && wr_free;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full     <= '0;
            wr_sel   <= BANK_A;
            rd_sel   <= BANK_A;
            beat     <= '0;
            overflow <= 1'b0;
        end else begin
            if (xfer) begin
                if (beat == LAST_BEAT) begin
                    beat   <= '0;
                    rd_sel <= (rd_sel == BANK_A) ? BANK_B : BANK_A;
                end else begin
                    beat <= beat + CW'(1);
                end
            end
            if (xfer_last) begin
                full[rd_sel] <= 1'b0;
            end
            // Ordered after the clear so a same-bank reload keeps the flag set.
            if (accept) begin
                full[wr_sel] <= 1'b1;
                wr_sel       <= (wr_sel == BANK_A) ? BANK_B : BANK_A;
            end
            if (vld_in && !wr_free) begin
                overflow <= 1'b1;
            end
        end
    end

    vec_bank #(
        .VEC_SIZE (VEC_SIZE),
        .CHUNK    (CHUNK),
        .BW       (BW),
        .RELU     (RELU),
        .CW       (CW)
    ) u_bank_a (
        .clk      (clk),
        .load     (accept && (wr_sel == BANK_A)),
        .data_in  (data_in),
        .beat     (beat),
        .data_out (rd_a)
    );

    vec_bank #(
        .VEC_SIZE (VEC_SIZE),
        .CHUNK    (CHUNK),
        .BW       (BW),
        .RELU     (RELU),
        .CW       (CW)
    ) u_bank_b (
        .clk      (clk),
        .load     (accept && (wr_sel == BANK_B)),
        .data_in  (data_in),
        .beat     (beat),
        .data_out (rd_b)
    );

    assign data_out = !vld_out ? '0 : ((rd_sel == BANK_A) ? rd_a : rd_b);
    assign last_out = vld_out && (beat == LAST_BEAT);
    assign busy     = |full;

endmodule

// File: tb/tb_dense_vec_serializer.sv
// Drives a ReLU and a pass-through serializer with identical stimulus against a queue-based model.
module tb_dense_vec_serializer;

    localparam int VS = 8;
    localparam int CH = 4;
    localparam int BW = 16;
    localparam int NB = VS / CH;

    typedef logic [VS-1:0][BW-1:0] vec_t;
    typedef logic [CH-1:0][BW-1:0] beat_t;

    logic  clk = 1'b0;
    logic  rst_n = 1'b0;
    logic  vld_in = 1'b0;
    logic  rdy_out = 1'b0;
    vec_t  data_in = '0;

    logic  vld_r, last_r, busy_r, ovf_r;
    logic  vld_p, last_p, busy_p, ovf_p;
    beat_t data_r, data_p;

    dense_vec_serializer #(.VEC_SIZE(VS), .CHUNK(CH), .BW(BW), .RELU(1)) dut_relu (
        .clk(clk), .rst_n(rst_n), .vld_in(vld_in), .data_in(data_in), .rdy_out(rdy_out),
        .vld_out(vld_r), .data_out(data_r), .last_out(last_r), .busy(busy_r), .overflow(ovf_r)
    );

    dense_vec_serializer #(.VEC_SIZE(VS), .CHUNK(CH), .BW(BW), .RELU(0)) dut_pass (
        .clk(clk), .rst_n(rst_n), .vld_in(vld_in), .data_in(data_in), .rdy_out(rdy_out),
        .vld_out(vld_p), .data_out(data_p), .last_out(last_p), .busy(busy_p), .overflow(ovf_p)
    );

    always #5 clk = ~clk;

    // Reference model: queue of accepted raw vectors, index of the beat on offer, sticky drop flag.
    vec_t  q[$];
    int    m_beat = 0;
    logic  m_ovf = 1'b0;
    int    n_checks = 0;
    int    n_pass = 0;
    int    xfers = 0;
    string phase = "reset";

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s/%s: got %h, expected %h", phase, tag, act, exp);
    endtask

    function automatic beat_t exp_beat(input bit relu_on);
        beat_t       b;
        logic [BW-1:0] e;
        b = '0;
        if (q.size() != 0) begin
            for (int j = 0; j < CH; j++) begin
                e = q[0][m_beat * CH + j];
                b[j] = (relu_on && e[BW-1]) ? '0 : e;
            end
        end
        return b;
    endfunction

    task automatic check_outputs();
        logic ev, el;
        ev = (q.size() != 0);
        el = ev && (m_beat == NB - 1);
        chk("vld_r",  64'(vld_r),  64'(ev));
        chk("vld_p",  64'(vld_p),  64'(ev));
        chk("last_r", 64'(last_r), 64'(el));
        chk("last_p", 64'(last_p), 64'(el));
        chk("busy_r", 64'(busy_r), 64'(ev));
        chk("busy_p", 64'(busy_p), 64'(ev));
        chk("ovf_r",  64'(ovf_r),  64'(m_ovf));
        chk("ovf_p",  64'(ovf_p),  64'(m_ovf));
        chk("data_r", 64'(data_r), 64'(exp_beat(1'b1)));
        chk("data_p", 64'(data_p), 64'(exp_beat(1'b0)));
    endtask

    task automatic model_edge();
        bit xfer, lastx, free_slot;
        xfer      = (q.size() != 0) && rdy_out;
        lastx     = xfer && (m_beat == NB - 1);
        free_slot = (q.size() < 2) || lastx;
        if (vld_r && rdy_out) xfers++;
        if (xfer) begin
            if (lastx) begin
                void'(q.pop_front());
                m_beat = 0;
            end else begin
                m_beat++;
            end
        end
        if (vld_in) begin
            if (free_slot) q.push_back(data_in);
            else m_ovf = 1'b1;
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    function automatic vec_t rand_vec();
        vec_t v;
        for (int i = 0; i < VS; i++) v[i] = BW'($urandom);
        return v;
    endfunction

    task automatic load(input vec_t v);
        data_in = v;
        vld_in  = 1'b1;
        step();
        vld_in  = 1'b0;
        data_in = rand_vec();
    endtask

    initial begin
        vec_t v;

        #3;
        check_outputs();
        #4 rst_n = 1'b1;
        @(posedge clk);
        #1;

        phase = "basic";
        rdy_out = 1'b1;
        for (int i = 0; i < VS; i++) v[i] = BW'(i + 1);
        load(v);
        chk("beat0", 64'(data_r), {16'd4, 16'd3, 16'd2, 16'd1});
        step();
        chk("beat1", 64'(data_r), {16'd8, 16'd7, 16'd6, 16'd5});
        chk("last_on_beat1", 64'(last_r), 64'd1);
        step();
        chk("busy_after", 64'(busy_r), 64'd0);

        phase = "relu";
        v[0] = 16'hFFFD; v[1] = 16'd2;    v[2] = 16'hFFFF; v[3] = 16'd0;
        v[4] = 16'd5;    v[5] = 16'h8000; v[6] = 16'd7;    v[7] = 16'd1;
        load(v);
        chk("relu_b0", 64'(data_r), {16'd0, 16'd0, 16'd2, 16'd0});
        chk("pass_b0", 64'(data_p), {16'd0, 16'hFFFF, 16'd2, 16'hFFFD});
        step();
        chk("relu_b1", 64'(data_r), {16'd1, 16'd7, 16'd0, 16'd5});
        chk("pass_b1", 64'(data_p), {16'd1, 16'd7, 16'h8000, 16'd5});
        step();

        phase = "backpressure";
        rdy_out = 1'b0;
        xfers = 0;
        load(rand_vec());
        repeat (5) step();
        rdy_out = 1'b1;
        repeat (3) step();
        chk("xfer_count", 64'(xfers), 64'd2);

        phase = "pingpong";
        load(rand_vec());
        load(rand_vec());
        load(rand_vec());
        repeat (7) step();
        chk("no_overflow", 64'(ovf_r), 64'd0);

        phase = "overflow";
        rdy_out = 1'b0;
        load(rand_vec());
        load(rand_vec());
        load(rand_vec());
        chk("ovf_set", 64'(ovf_r), 64'd1);
        repeat (2) step();
        rdy_out = 1'b1;
        xfers = 0;
        repeat (6) step();
        chk("two_vectors_out", 64'(xfers), 64'(2 * NB));

        phase = "async_reset";
        load(rand_vec());
        step();
        #2 rst_n = 1'b0;
        #1;
        q.delete();
        m_beat = 0;
        m_ovf  = 1'b0;
        check_outputs();
        #3 rst_n = 1'b1;
        step();
        load(rand_vec());
        repeat (3) step();

        phase = "random";
        repeat (400) begin
            vld_in  = ($urandom_range(0, 99) < 30);
            data_in = rand_vec();
            rdy_out = ($urandom_range(0, 99) < 70);
            step();
        end
        vld_in  = 1'b0;
        rdy_out = 1'b1;
        repeat (6) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
